mem_access_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM pipeline register and feeding the write-back stage.
- Resolves branches from the registered zero flag and branch code.
- Runs load/store transactions on a request/acknowledge data-memory bus, with a stall back to EX/MEM while a transaction is outstanding.
- Registers results into the MEM/WB boundary.
- Flags misaligned accesses and, optionally, bus timeouts.

---
 rtl/mem_access_stage.sv | 148 ++++++++++++++
 tb/tb_mem_access_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: branch resolve, req/ack data-memory bus, MEM/WB register (optional timeout: MEM_TIMEOUT_EN)
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic [31:0] alu_c,
    input  logic [31:0] rt_data,
    input  logic        zero,
    input  logic [4:0]  reg_rd,
    input  logic [1:0]  branch,
    input  logic        memr,
    input  logic        memw,
    input  logic        regw,
    input  logic        mem2reg,
    output logic        pc_src,
    output logic [31:0] br_target,
    output logic        mem_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        wb_valid,
    output logic        wb_regw,
    output logic        wb_mem2reg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_alu_c,
    output logic [31:0] wb_mem_data,
    output logic        align_err,
    output logic        bus_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state;
    logic       access;
    logic       aligned;
    logic       abort;

    assign access  = memr | memw;
    assign aligned = (alu_c[1:0] == 2'b00);

    always_comb begin
        pc_src = 1'b0;
        case (branch)
            2'b01:   pc_src = zero;
            2'b10:   pc_src = ~zero;
            2'b11:   pc_src = 1'b1;
            default: pc_src = 1'b0;
        endcase
    end

    assign br_target = npc;
    assign mem_stall = ((state == IDLE) & access & aligned)
                     | ((state == BUSY) & ~dm_ack & ~abort);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt;

    assign abort = (state == BUSY) && (to_cnt == CW'(TIMEOUT - 1)) && !dm_ack;

    // Held at zero in IDLE, so it starts from zero on every entry to BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            if (state == IDLE)
                to_cnt <= '0;
            else if (!dm_ack)
                to_cnt <= to_cnt + 1'b1;
            if (abort)
                bus_err <= 1'b1;
        end
    end
`else
    assign abort   = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            wb_valid    <= 1'b0;
            wb_regw     <= 1'b0;
            wb_mem2reg  <= 1'b0;
            wb_rd       <= '0;
            wb_alu_c    <= '0;
            wb_mem_data <= '0;
            align_err   <= 1'b0;
        end else begin
            // MEM/WB defaults to a bubble; only completing instructions override it.
            wb_valid    <= 1'b0;
            wb_regw     <= 1'b0;
            wb_mem2reg  <= 1'b0;
            wb_rd       <= '0;
            wb_alu_c    <= '0;
            wb_mem_data <= '0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            dm_addr  <= alu_c;
                            dm_wdata <= rt_data;
                            dm_we    <= memw;
                            dm_req   <= 1'b1;
                            state    <= BUSY;
                        end else begin
                            align_err <= 1'b1;
                        end
                    end else begin
                        wb_valid   <= 1'b1;
                        wb_regw    <= regw;
                        wb_mem2reg <= mem2reg;
                        wb_rd      <= reg_rd;
                        wb_alu_c   <= alu_c;
                    end
                end
                BUSY: begin
                    if (dm_ack) begin
                        dm_req      <= 1'b0;
                        state       <= IDLE;
                        wb_valid    <= 1'b1;
                        wb_regw     <= regw;
                        wb_mem2reg  <= mem2reg;
                        wb_rd       <= reg_rd;
                        wb_alu_c    <= alu_c;
                        wb_mem_data <= dm_we ? 32'd0 : dm_rdata;
                    end else if (abort) begin
                        dm_req <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc, alu_c, rt_data, dm_rdata;
    logic        zero, memr, memw, regw, mem2reg, dm_ack;
    logic [4:0]  reg_rd;
    logic [1:0]  branch;
    logic        pc_src, mem_stall, dm_req, dm_we;
    logic [31:0] br_target, dm_addr, dm_wdata, wb_alu_c, wb_mem_data;
    logic        wb_valid, wb_regw, wb_mem2reg, align_err, bus_err;
    logic [4:0]  wb_rd;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_align = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .npc(npc), .alu_c(alu_c), .rt_data(rt_data),
        .zero(zero), .reg_rd(reg_rd), .branch(branch), .memr(memr), .memw(memw),
        .regw(regw), .mem2reg(mem2reg), .pc_src(pc_src), .br_target(br_target),
        .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .wb_valid(wb_valid), .wb_regw(wb_regw), .wb_mem2reg(wb_mem2reg),
        .wb_rd(wb_rd), .wb_alu_c(wb_alu_c), .wb_mem_data(wb_mem_data),
        .align_err(align_err), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_taken(input logic [1:0] br, input logic z);
        if (br == 2'd3) return 1'b1;
        if (br == 2'd1) return z;
        if (br == 2'd2) return !z;
        return 1'b0;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] rt, input logic [31:0] np,
                         input logic m_r, input logic m_w, input logic rw, input logic m2r,
                         input logic [4:0] rd, input logic [1:0] br, input logic z);
        alu_c = a; rt_data = rt; npc = np; memr = m_r; memw = m_w;
        regw = rw; mem2reg = m2r; reg_rd = rd; branch = br; zero = z;
    endtask

    // Runs the currently driven instruction to completion; called at posedge+1.
    task automatic run_instr(input logic [31:0] rdata, input int delay, input bit idle_ack);
        bit acc, al;
        acc = memr | memw;
        al  = (alu_c[1:0] == 2'b00);
        @(negedge clk);
        check("pc_src", 32'(pc_src), 32'(model_taken(branch, zero)));
        check("br_target", br_target, npc);
        if (!acc) begin
            check("stall_none", 32'(mem_stall), 0);
            dm_ack = idle_ack;
            @(posedge clk); #1;
            dm_ack = 1'b0;
            check("wb_valid_none", 32'(wb_valid), 1);
            check("wb_regw_none", 32'(wb_regw), 32'(regw));
            check("wb_m2r_none", 32'(wb_mem2reg), 32'(mem2reg));
            check("wb_rd_none", 32'(wb_rd), 32'(reg_rd));
            check("wb_alu_none", wb_alu_c, alu_c);
            check("wb_mem_none", wb_mem_data, 0);
            check("req_none", 32'(dm_req), 0);
        end else if (!al) begin
            exp_align = 1'b1;
            check("stall_misal", 32'(mem_stall), 0);
            @(posedge clk); #1;
            check("req_misal", 32'(dm_req), 0);
            check("wb_valid_misal", 32'(wb_valid), 0);
            check("wb_regw_misal", 32'(wb_regw), 0);
        end else begin
            check("stall_c0", 32'(mem_stall), 1);
            @(posedge clk); #1;
            check("req_c1", 32'(dm_req), 1);
            check("dm_we", 32'(dm_we), 32'(memw));
            check("dm_addr", dm_addr, alu_c);
            check("dm_wdata", dm_wdata, rt_data);
            check("wb_valid_c0", 32'(wb_valid), 0);
            for (int c = 1; c < delay; c++) begin
                @(negedge clk);
                check("stall_wait", 32'(mem_stall), 1);
                @(posedge clk); #1;
                check("req_wait", 32'(dm_req), 1);
                check("wb_valid_wait", 32'(wb_valid), 0);
                check("dm_addr_hold", dm_addr, alu_c);
            end
            dm_ack = 1'b1;
            dm_rdata = rdata;
            @(negedge clk);
            check("stall_ack", 32'(mem_stall), 0);
            @(posedge clk); #1;
            dm_ack = 1'b0;
            check("req_done", 32'(dm_req), 0);
            check("wb_valid_done", 32'(wb_valid), 1);
            check("wb_regw_done", 32'(wb_regw), 32'(regw));
            check("wb_rd_done", 32'(wb_rd), 32'(reg_rd));
            check("wb_alu_done", wb_alu_c, alu_c);
            check("wb_mem_done", wb_mem_data, memr ? rdata : 32'd0);
        end
        check("align_err", 32'(align_err), 32'(exp_align));
    endtask

    initial begin
        rst = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dm_req), 0);
        check("rst_addr", dm_addr, 0);
        check("rst_wdata", dm_wdata, 0);
        check("rst_we", 32'(dm_we), 0);
        check("rst_wb", {wb_valid, wb_regw, wb_mem2reg, wb_rd}, 0);
        check("rst_wb_data", wb_alu_c | wb_mem_data, 0);
        check("rst_errs", {align_err, bus_err}, 0);
        rst = 1'b1;

        // Load with ack in cycle 1
        drive(32'h100, 0, 32'h20, 1, 0, 1, 1, 5, 0, 0);
        run_instr(32'hDEADBEEF, 1, 0);
        // Store, ack in cycle 3
        drive(32'h40, 32'h1234, 32'h24, 0, 1, 0, 0, 0, 0, 0);
        run_instr(32'h55AA55AA, 3, 0);
        // Misaligned load
        drive(32'h102, 0, 32'h28, 1, 0, 1, 1, 7, 0, 0);
        run_instr(0, 1, 0);
        // Branches
        drive(32'h0, 0, 32'h1000, 0, 0, 0, 0, 1, 2'b01, 1);
        run_instr(0, 1, 0);
        drive(32'h0, 0, 32'h2000, 0, 0, 0, 0, 1, 2'b10, 1);
        run_instr(0, 1, 0);
        drive(32'h0, 0, 32'h3000, 0, 0, 0, 0, 1, 2'b11, 0);
        run_instr(0, 1, 1);

        // Reset mid-BUSY, then a late ack must be ignored
        drive(32'h200, 0, 0, 1, 0, 1, 1, 3, 0, 0);
        @(posedge clk); #1;
        check("busy_req", 32'(dm_req), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_req", 32'(dm_req), 0);
        check("midrst_wb", {wb_valid, wb_regw, wb_mem2reg, wb_rd}, 0);
        check("midrst_align", 32'(align_err), 0);
        exp_align = 1'b0;
        drive(32'h300, 0, 0, 0, 0, 1, 0, 9, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_instr(0, 1, 1);
        drive(32'h204, 0, 0, 1, 0, 1, 1, 4, 0, 0);
        run_instr(32'hCAFEF00D, 2, 0);

`ifdef MEM_TIMEOUT_EN
        begin
            int hi;
            hi = 0;
            drive(32'h80, 0, 0, 1, 0, 1, 1, 6, 0, 0);
            @(posedge clk); #1;
            while (dm_req && hi < 20) begin
                hi++;
                @(posedge clk); #1;
            end
            check("to_req_cycles", hi, 4);
            check("to_bus_err", 32'(bus_err), 1);
            check("to_wb_valid", 32'(wb_valid), 0);
            check("to_wb_regw", 32'(wb_regw), 0);
            check("to_wb_mem", wb_mem_data, 0);
            drive(32'h84, 0, 0, 0, 0, 1, 0, 2, 0, 0);
            run_instr(0, 1, 0);
        end
`endif

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            int op;
            logic [31:0] a;
            op = int'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            drive(a, $urandom, $urandom, op == 1, op == 2, 1'($urandom), 1'($urandom),
                  5'($urandom), 2'($urandom), 1'($urandom));
            run_instr($urandom, int'($urandom_range(1, 4)), 1'($urandom));
        end

`ifndef MEM_TIMEOUT_EN
        check("bus_err_tied", 32'(bus_err), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
